// File: rtl/highlight_pkg.sv
// highlight_pkg: pixel type, FSM states and the red-tint merge function
// shared by the highlight path.
package highlight_pkg;
    localparam int BYTES_PER_PIXEL = 3;
    typedef struct packed {logic [7:0] b, g, r;} pixel_t;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic pixel_t highlight_px(pixel_t ped, pixel_t mask, logic [7:0] thr);
        pixel_t px;
        px = ped;
        if (mask.b >= thr || mask.g >= thr || mask.r >= thr) begin
            px.r = 8'hFF;
            px.g = ped.g >> 1;
            px.b = ped.b >> 1;
        end
        return px;
    endfunction
endpackage

// File: rtl/highlight_merge.sv
// highlight_merge: pops ped and mask FWFT FIFOs in lockstep, tints masked pixels red
// through a one-stage register, and tracks frame boundaries.
module highlight_merge
    import highlight_pkg::*;
#(
    parameter int unsigned WIDTH       = 768,
    parameter int unsigned HEIGHT      = 576,
    parameter logic [7:0]  MASK_THRESH = 8'd128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_empty_ped,
    output logic        in_rd_en_ped,
    input  logic [23:0] in_dout_ped,
    input  logic        in_empty_mask,
    output logic        in_rd_en_mask,
    input  logic [23:0] in_dout_mask,
    input  logic        out_full,
    output logic        out_wr_en,
    output logic [23:0] out_din,
    output logic        frame_done,
    output logic        busy
);
    localparam int unsigned NPIX = WIDTH * HEIGHT;
    localparam int CW = NPIX > 1 ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

    state_t state_q, state_d;
    logic valid_q, valid_d, frame_done_q, frame_done_d;
    pixel_t data_q, data_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic accept, push, last;

    // Pop gated by reset so the FIFOs are never drained while the block is held in reset.
    always_comb begin
        accept = !reset && !in_empty_ped && !in_empty_mask && (!valid_q || !out_full);
        push = valid_q && !out_full;
        last = push && pix_cnt_q == LAST;
        valid_d = accept || (valid_q && out_full);
        data_d = accept ? highlight_px(pixel_t'(in_dout_ped), pixel_t'(in_dout_mask), MASK_THRESH) : data_q;
        pix_cnt_d = last ? '0 : pix_cnt_q + CW'(push);
        frame_done_d = last;
        state_d = accept ? RUN : last ? IDLE : state_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q <= '0;
            pix_cnt_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q <= data_d;
            pix_cnt_q <= pix_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_rd_en_ped = accept;
    assign in_rd_en_mask = accept;
    assign out_wr_en = push;
    assign out_din = data_q;
    assign frame_done = frame_done_q;
    assign busy = state_q == RUN;
endmodule
